ascii_frame_decoder: RTL and testbench



---
 rtl/ascii_frame_decoder_if.sv | 23 ++
 rtl/ascii_frame_decoder.sv | 122 ++++++++++++
 tb/tb_ascii_frame_decoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ascii_frame_decoder_if.sv
// ascii_frame_decoder_if: received-byte input and decoded channel outputs of the frame decoder
interface ascii_frame_decoder_if #(
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 20
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic [7:0]              pi_data;
    logic                    pi_sig;
    logic [NUM_CH*OUT_W-1:0] data_dis;
    logic                    dout_valid;
    logic [CW-1:0]           dout_ch;
    logic                    err_pulse;
    logic [2:0]              err_code;
    logic                    busy;
    modport master (
        output pi_data, pi_sig,
        input  data_dis, dout_valid, dout_ch, err_pulse, err_code, busy
    );
    modport slave (
        input  pi_data, pi_sig,
        output data_dis, dout_valid, dout_ch, err_pulse, err_code, busy
    );
endinterface

// File: rtl/ascii_frame_decoder.sv
// ascii_frame_decoder: parses "$<ch><digits>CR" byte frames into per-channel held values
module ascii_frame_decoder #(
    parameter int         NUM_CH      = 2,
    parameter int         MAX_DIGITS  = 5,
    parameter int         OUT_W       = 20,
    parameter logic [7:0] START_CHAR  = 8'h24,
    parameter logic [7:0] TERM_CHAR   = 8'h0D,
    parameter int         TIMEOUT_CYC = 500000
) (
    input logic               clk,
    input logic               rst,
    ascii_frame_decoder_if.slave bus
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int AW = OUT_W + 4;
    localparam logic [AW-1:0] MAXV = {4'b0, {OUT_W{1'b1}}};
    typedef enum logic [1:0] {IDLE, CHAN, DIGITS} state_t;
    state_t                  r_state, w_state_n;
    logic [AW-1:0]           r_acc, w_prod;
    logic [3:0]              r_cnt, w_d;
    logic                    r_ovf, r_valid, r_err, r_busy;
    logic [CW-1:0]           r_ch, r_dout_ch;
    logic [31:0]             r_tmo;
    logic [NUM_CH*OUT_W-1:0] r_data;
    logic [2:0]              r_code, w_code;
    logic                    w_is_dig, w_is_start, w_is_term, w_tmo, w_err, w_upd, w_clr, w_acc;

    assign w_d        = bus.pi_data[3:0];
    assign w_is_dig   = bus.pi_data >= 8'h30 && bus.pi_data <= 8'h39;
    assign w_is_start = bus.pi_data == START_CHAR;
    assign w_is_term  = bus.pi_data == TERM_CHAR;
    // accumulator is 4 bits wider than the output so acc*10+9 never wraps
    assign w_prod     = r_acc * AW'(10) + AW'(w_d);
    assign w_tmo      = TIMEOUT_CYC != 0 && r_state != IDLE && r_tmo == 32'(TIMEOUT_CYC);

    always_comb begin
        w_state_n = r_state;
        w_err     = 1'b0;
        w_code    = 3'd0;
        w_upd     = 1'b0;
        w_clr     = 1'b0;
        w_acc     = 1'b0;
        if (bus.pi_sig) begin
            case (r_state)
                IDLE: w_state_n = w_is_start ? CHAN : IDLE;
                CHAN: begin
                    if (w_is_dig && 32'(w_d) < NUM_CH) begin
                        w_clr     = 1'b1;
                        w_state_n = DIGITS;
                    end else begin
                        w_err     = 1'b1;
                        w_code    = w_is_dig ? 3'd1 : w_is_start ? 3'd7 : 3'd2;
                        w_state_n = w_is_start ? CHAN : IDLE;
                    end
                end
                DIGITS: begin
                    if (w_is_dig && r_cnt != 4'(MAX_DIGITS)) begin
                        w_acc = 1'b1;
                    end else if (w_is_term && r_cnt != 4'd0 && !r_ovf) begin
                        w_upd     = 1'b1;
                        w_state_n = IDLE;
                    end else begin
                        w_err     = 1'b1;
                        w_code    = w_is_dig ? 3'd3 : w_is_term ? (r_cnt == 4'd0 ? 3'd4 : 3'd5) :
                                    w_is_start ? 3'd7 : 3'd2;
                        w_state_n = (!w_is_dig && !w_is_term && w_is_start) ? CHAN : IDLE;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end else if (w_tmo) begin
            w_err     = 1'b1;
            w_code    = 3'd6;
            w_state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_ch      <= '0;
            r_tmo     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_dout_ch <= '0;
            r_err     <= 1'b0;
            r_code    <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_tmo   <= (bus.pi_sig || r_state == IDLE) ? '0 : r_tmo + 32'd1;
            if (w_clr) begin
                r_ch  <= CW'(w_d);
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end
            if (w_acc) begin
                r_acc <= w_prod > MAXV ? MAXV : w_prod;
                r_cnt <= r_cnt + 4'd1;
                r_ovf <= r_ovf | (w_prod > MAXV);
            end
            for (int k = 0; k < NUM_CH; k++)
                if (w_upd && r_ch == CW'(k)) r_data[k*OUT_W +: OUT_W] <= r_acc[OUT_W-1:0];
            if (w_upd) r_dout_ch <= r_ch;
            r_valid <= w_upd;
            r_err   <= w_err;
            if (w_err) r_code <= w_code;
            r_busy  <= w_state_n != IDLE;
        end
    end

    assign bus.data_dis   = r_data;
    assign bus.dout_valid = r_valid;
    assign bus.dout_ch    = r_dout_ch;
    assign bus.err_pulse  = r_err;
    assign bus.err_code   = r_code;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_ascii_frame_decoder.sv
// tb_ascii_frame_decoder: directed frames with hand-computed results, 16-bit channels, 100-cycle timeout
module tb_ascii_frame_decoder;
    localparam int         OUT_W = 16;
    localparam logic [7:0] CR    = 8'h0D;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    ascii_frame_decoder_if #(.NUM_CH(2), .OUT_W(OUT_W)) bus();
    ascii_frame_decoder #(
        .NUM_CH(2), .MAX_DIGITS(5), .OUT_W(OUT_W),
        .START_CHAR(8'h24), .TERM_CHAR(8'h0D), .TIMEOUT_CYC(100)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [OUT_W-1:0] w_ch0, w_ch1;
    assign w_ch0 = bus.data_dis[OUT_W-1:0];
    assign w_ch1 = bus.data_dis[2*OUT_W-1:OUT_W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // all stimulus changes at negedge; outputs are read at the negedge after the sampling posedge
    task automatic put(input logic [7:0] b);
        bus.pi_sig  = 1'b1;
        bus.pi_data = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.pi_sig = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0 && gap > 0) idle(gap);
            put(s[i]);
        end
    endtask

    initial begin
        bus.pi_sig  = 1'b0;
        bus.pi_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_data", bus.data_dis, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_code", bus.err_code, 0);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_err", bus.err_pulse, 0);
        rst = 1'b0;
        idle(2);

        send("$1123", 1); idle(1); put(CR);
        check("f1_valid", bus.dout_valid, 1);
        check("f1_ch", bus.dout_ch, 1);
        check("f1_ch1", w_ch1, 123);
        check("f1_ch0", w_ch0, 0);
        check("f1_busy", bus.busy, 0);
        check("f1_err", bus.err_pulse, 0);
        idle(1);
        check("f1_pulse_len", bus.dout_valid, 0);

        idle(2); send("$065535", 1); idle(1); put(CR);
        check("max_valid", bus.dout_valid, 1);
        check("max_ch0", w_ch0, 65535);
        check("max_dch", bus.dout_ch, 0);
        idle(1); send("$065536", 0); put(CR);
        check("ovf_err", bus.err_pulse, 1);
        check("ovf_code", bus.err_code, 5);
        check("ovf_valid", bus.dout_valid, 0);
        check("ovf_ch0", w_ch0, 65535);

        idle(1); send("$012345", 1); idle(1); put(8'h36);
        check("long_err", bus.err_pulse, 1);
        check("long_code", bus.err_code, 3);
        check("long_busy", bus.busy, 0);
        put(CR);
        check("long_cr_err", bus.err_pulse, 0);
        check("long_cr_valid", bus.dout_valid, 0);
        check("long_ch0", w_ch0, 65535);

        idle(1); send("$9", 1);
        check("badch_err", bus.err_pulse, 1);
        check("badch_code", bus.err_code, 1);
        idle(1); send("$1", 1); idle(1); put(CR);
        check("empty_err", bus.err_pulse, 1);
        check("empty_code", bus.err_code, 4);
        idle(1); send("$1 ", 1);
        check("badchar_code", bus.err_code, 2);
        check("badchar_busy", bus.busy, 0);
        idle(1); send("$12$", 1);
        check("resync_err", bus.err_pulse, 1);
        check("resync_code", bus.err_code, 7);
        check("resync_busy", bus.busy, 1);
        idle(1); send("07", 1); idle(1); put(CR);
        check("resync_valid", bus.dout_valid, 1);
        check("resync_ch0", w_ch0, 7);
        check("resync_ch1", w_ch1, 123);
        check("resync_code_held", bus.err_code, 7);
        check("resync_no_err", bus.err_pulse, 0);

        idle(1); send("$1", 1); idle(100);
        check("tmo_early_err", bus.err_pulse, 0);
        check("tmo_early_busy", bus.busy, 1);
        idle(1);
        check("tmo_err", bus.err_pulse, 1);
        check("tmo_code", bus.err_code, 6);
        check("tmo_busy", bus.busy, 0);
        idle(1);
        check("tmo_pulse_len", bus.err_pulse, 0);
        send("$1", 1); idle(100); put(8'h35);
        check("tmo_race_err", bus.err_pulse, 0);
        check("tmo_race_busy", bus.busy, 1);
        put(CR);
        check("tmo_race_valid", bus.dout_valid, 1);
        check("tmo_race_ch1", w_ch1, 5);

        idle(1); send("$04", 1); idle(1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_data", bus.data_dis, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_code", bus.err_code, 0);
        check("mid_rst_err", bus.err_pulse, 0);
        check("mid_rst_dch", bus.dout_ch, 0);
        rst = 1'b0;
        idle(1);
        check("post_rst_err", bus.err_pulse, 0);
        send("$05", 1); idle(1); put(CR);
        check("post_rst_ch0", w_ch0, 5);
        idle(1); send("$042\015", 0);
        check("b2b_valid", bus.dout_valid, 1);
        check("b2b_ch0", w_ch0, 42);
        check("b2b_ch1", w_ch1, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
